// File: rtl/grid_cursor.sv
// grid_cursor: button-driven column/row cursor on a COLS x ROWS grid.
// Emits sprite pixel origin, linear cell index, move and select pulses.
module grid_cursor #(
    parameter int COLS     = 3,
    parameter int ROWS     = 3,
    parameter int ORIGIN_X = 73,
    parameter int ORIGIN_Y = 47,
    parameter int PITCH_X  = 210,
    parameter int PITCH_Y  = 158,
    parameter int POS_W    = 10,
    parameter int WRAP     = 1,
    parameter int IDX_W    = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_right,
    input  logic             btn_left,
    input  logic             btn_down,
    input  logic             btn_up,
    input  logic             btn_home,
    input  logic             btn_select,
    output logic [POS_W-1:0] posx,
    output logic [POS_W-1:0] posy,
    output logic [IDX_W-1:0] cell_index,
    output logic             moved,
    output logic             select_strobe,
    output logic [IDX_W-1:0] select_index
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(COLS - 1);
    localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
    localparam longint MAXX = longint'(ORIGIN_X) + longint'(COLS - 1) * PITCH_X;
    localparam longint MAXY = longint'(ORIGIN_Y) + longint'(ROWS - 1) * PITCH_Y;
    localparam longint PLIM = longint'(1) << POS_W;

    if (MAXX >= PLIM || MAXY >= PLIM) begin : g_pos_overflow
        $error("grid_cursor: pixel position does not fit in POS_W bits");
    end

    logic [5:0]       btn_q;
    logic [5:0]       btn_now;
    logic [5:0]       rise;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [POS_W-1:0] posx_q, posx_d;
    logic [POS_W-1:0] posy_q, posy_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] sel_idx_q;
    logic             moved_q, moved_d;
    logic             strobe_q;

    // bit order: 0 right, 1 left, 2 down, 3 up, 4 home, 5 select
    assign btn_now = {btn_select, btn_home, btn_up, btn_down, btn_left, btn_right};
    assign rise    = btn_now & ~btn_q;

    // next column/row from edge-detected buttons; home wins, opposing pair cancels
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (rise[4]) begin
            col_d = '0;
            row_d = '0;
        end else begin
            if (rise[0] && !rise[1]) begin
                if (col_q == CMAX) col_d = (WRAP != 0) ? '0 : col_q;
                else               col_d = col_q + CW'(1);
            end else if (rise[1] && !rise[0]) begin
                if (col_q == '0) col_d = (WRAP != 0) ? CMAX : col_q;
                else             col_d = col_q - CW'(1);
            end
            if (rise[2] && !rise[3]) begin
                if (row_q == RMAX) row_d = (WRAP != 0) ? '0 : row_q;
                else               row_d = row_q + RW'(1);
            end else if (rise[3] && !rise[2]) begin
                if (row_q == '0) row_d = (WRAP != 0) ? RMAX : row_q;
                else             row_d = row_q - RW'(1);
            end
        end
    end

    // derived outputs computed from the next position so they track the counters
    always_comb begin
        posx_d  = POS_W'(ORIGIN_X) + POS_W'(col_d) * POS_W'(PITCH_X);
        posy_d  = POS_W'(ORIGIN_Y) + POS_W'(row_d) * POS_W'(PITCH_Y);
        idx_d   = IDX_W'(row_d) * IDX_W'(COLS) + IDX_W'(col_d);
        moved_d = {row_d, col_d} != {row_q, col_q};
    end

    // state registers; button history resets high so held buttons do not fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q     <= '1;
            col_q     <= '0;
            row_q     <= '0;
            posx_q    <= POS_W'(ORIGIN_X);
            posy_q    <= POS_W'(ORIGIN_Y);
            idx_q     <= '0;
            moved_q   <= 1'b0;
            strobe_q  <= 1'b0;
            sel_idx_q <= '0;
        end else begin
            btn_q    <= btn_now;
            col_q    <= col_d;
            row_q    <= row_d;
            posx_q   <= posx_d;
            posy_q   <= posy_d;
            idx_q    <= idx_d;
            moved_q  <= moved_d;
            strobe_q <= rise[5];
            if (rise[5]) sel_idx_q <= idx_q;
        end
    end

    assign posx          = posx_q;
    assign posy          = posy_q;
    assign cell_index    = idx_q;
    assign moved         = moved_q;
    assign select_strobe = strobe_q;
    assign select_index  = sel_idx_q;

endmodule

// File: tb/tb_grid_cursor.sv
// tb_grid_cursor: directed checks of a wrapping and a saturating cursor.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_grid_cursor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] a = '0;
    logic [5:0] b = '0;

    logic [9:0] ax, ay, bx, by;
    logic [3:0] aidx, asel, bidx, bsel;
    logic am, as, bm, bs;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    grid_cursor #(.WRAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .btn_right(a[0]), .btn_left(a[1]), .btn_down(a[2]),
        .btn_up(a[3]), .btn_home(a[4]), .btn_select(a[5]),
        .posx(ax), .posy(ay), .cell_index(aidx), .moved(am),
        .select_strobe(as), .select_index(asel)
    );

    grid_cursor #(.WRAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .btn_right(b[0]), .btn_left(b[1]), .btn_down(b[2]),
        .btn_up(b[3]), .btn_home(b[4]), .btn_select(b[5]),
        .posx(bx), .posy(by), .cell_index(bidx), .moved(bm),
        .select_strobe(bs), .select_index(bsel)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input int x, input int y,
                         input int idx, input int mv);
        chk({tag, ".posx"}, int'(ax), x);
        chk({tag, ".posy"}, int'(ay), y);
        chk({tag, ".idx"}, int'(aidx), idx);
        chk({tag, ".moved"}, int'(am), mv);
    endtask

    initial begin
        // reset with right held
        a = 6'b000001;
        repeat (3) tick();
        chk_a("rst", 73, 47, 0, 0);
        chk("rst.strobe", int'(as), 0);
        chk("rst.sel", int'(asel), 0);
        chk("rst.b_posy", int'(by), 47);
        rst_n = 1'b1;
        tick();
        tick();
        chk_a("held", 73, 47, 0, 0);
        a = '0; tick();
        chk_a("released", 73, 47, 0, 0);

        // right x3 with wrap
        a = 6'b000001; tick();
        chk_a("r1", 283, 47, 1, 1);
        tick();
        chk_a("r1.hold", 283, 47, 1, 0);
        a = '0; tick();
        a = 6'b000001; tick();
        chk_a("r2", 493, 47, 2, 1);
        a = '0; tick();
        chk("r2.pulse", int'(am), 0);
        a = 6'b000001; tick();
        chk_a("r3.wrap", 73, 47, 0, 1);
        a = '0; tick();
        chk("r3.pulse", int'(am), 0);

        // saturating instance: left at col 0, then down x3
        b = 6'b000010; tick();
        chk("b.left.posx", int'(bx), 73);
        chk("b.left.moved", int'(bm), 0);
        b = '0; tick();
        b = 6'b000100; tick();
        chk("b.d1.posy", int'(by), 205);
        chk("b.d1.moved", int'(bm), 1);
        b = '0; tick();
        chk("b.d1.pulse", int'(bm), 0);
        b = 6'b000100; tick();
        chk("b.d2.posy", int'(by), 363);
        chk("b.d2.moved", int'(bm), 1);
        b = '0; tick();
        b = 6'b000100; tick();
        chk("b.d3.posy", int'(by), 363);
        chk("b.d3.moved", int'(bm), 0);
        chk("b.d3.idx", int'(bidx), 6);
        b = '0; tick();

        // opposing pair, then diagonal
        a = 6'b000011; tick();
        chk_a("rl", 73, 47, 0, 0);
        a = '0; tick();
        a = 6'b000101; tick();
        chk_a("diag", 283, 205, 4, 1);
        a = '0; tick();
        chk("diag.pulse", int'(am), 0);

        // select with a move in the same cycle
        a = 6'b100001; tick();
        chk_a("selmv", 493, 205, 5, 1);
        chk("selmv.strobe", int'(as), 1);
        chk("selmv.sel", int'(asel), 4);
        a = '0; tick();
        chk("selmv.strobe0", int'(as), 0);
        chk("selmv.sel_hold", int'(asel), 4);

        // held select gives a single strobe
        a = 6'b100000; tick();
        chk("hold.strobe", int'(as), 1);
        chk("hold.sel", int'(asel), 5);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("hold.quiet", int'(as), 0);
        end
        a = '0; tick();

        // move to cell 8, then home+down+right
        a = 6'b000100; tick();
        chk_a("to8", 493, 363, 8, 1);
        a = '0; tick();
        a = 6'b010101; tick();
        chk_a("home", 73, 47, 0, 1);
        a = '0; tick();
        a = 6'b010000; tick();
        chk_a("home.origin", 73, 47, 0, 0);
        a = '0; tick();

        // asynchronous reset mid-cycle
        a = 6'b000001; tick();
        chk_a("pre_rst", 283, 47, 1, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_a("async", 73, 47, 0, 0);
        chk("async.sel", int'(asel), 0);
        chk("async.b_posy", int'(by), 47);
        tick();
        rst_n = 1'b1;
        tick();
        chk_a("post_rst", 73, 47, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/grid_cursor.md
# grid_cursor

Parametrised cursor for the board-style VGA graphics path. It tracks a column/row selection on a COLS x ROWS grid, driven by debounced direction buttons. It outputs the sprite's top-left pixel position and the linear cell index, and issues a one-cycle select strobe for the game logic. It generalises the fixed 3x3, increment-only position block:

- runs on one clock with edge detection;
- moves in both directions;
- has a home command;
- wraps or saturates at the edges, chosen by parameter.

## Interface
Parameters:
- COLS, 3: grid columns (>=1)
- ROWS, 3: grid rows (>=1)
- ORIGIN_X, 73: pixel x of column 0
- ORIGIN_Y, 47: pixel y of row 0
- PITCH_X, 210: pixel step per column
- PITCH_Y, 158: pixel step per row
- POS_W, 10: width of posx/posy
- WRAP, 1: 1 = wrap at edges, 0 = saturate at edges
- IDX_W, $clog2(COLS*ROWS) (min 1): width of cell_index/select_index

Ports:
- clk  in  1  system clock (pixel-domain clock)
- rst_n  in  1  reset; one clock, asynchronous assertion, active-low
- btn_right  in  1  level; rising edge moves col +1
- btn_left  in  1  level; rising edge moves col -1
- btn_down  in  1  level; rising edge moves row +1
- btn_up  in  1  level; rising edge moves row -1
- btn_home  in  1  level; rising edge moves to col 0, row 0
- btn_select  in  1  level; rising edge requests select
- posx  out  POS_W  ORIGIN_X + col*PITCH_X
- posy  out  POS_W  ORIGIN_Y + row*PITCH_Y
- cell_index  out  IDX_W  row*COLS + col
- moved  out  1  one-cycle pulse when col or row changed
- select_strobe  out  1  one-cycle select pulse
- select_index  out  IDX_W  cell latched at select; holds until next select

## Operation
- Inputs are already synchronous and debounced. No synchroniser is required inside the block.
- Each button has a previous-value register. A rise is defined as `btn & ~btn_q`.
- Column update, per clock:
  - home rise: col = 0 (overrides all moves).
  - right rise and left rise together: no change.
  - right rise only: col+1. At COLS-1, go to 0 if WRAP=1, else hold.
  - left rise only: col-1. At 0, go to COLS-1 if WRAP=1, else hold.
- Row update follows the same rules with down/up/ROWS.
- X and Y moves are independent. Both can occur in the same cycle.
- moved = 1 only if the new {row,col} differs from the old. A saturated move, a home command while already at (0,0), and an opposing pair all give moved = 0.
- Select on a rise of btn_select:
  - select_index <= current (pre-move) cell_index;
  - select_strobe = 1 for exactly one cycle.
  - Select is independent of moves in the same cycle.
- Arithmetic:
  - col is $clog2(COLS) wide (min 1); row is $clog2(ROWS) wide (min 1).
  - Products are computed in POS_W bits.
  - An elaboration assertion fails if ORIGIN_X+(COLS-1)*PITCH_X or ORIGIN_Y+(ROWS-1)*PITCH_Y >= 2^POS_W.
- col and row never leave [0,COLS-1] and [0,ROWS-1]. For COLS=1, left/right never move and never pulse moved.

## Timing
- All outputs are registered. posx, posy and cell_index are computed from next col/row, so they change on the same edge as the counters.
- Latency: a button high at clock edge k (low at k-1) gives updated outputs and a moved/select pulse after edge k. The pulse is deasserted after edge k+1.
- A held button produces exactly one action. Re-triggering requires a low for at least one sampled cycle.
- Reset (rst_n low, asynchronous) sets:
  - col = row = 0;
  - posx = ORIGIN_X, posy = ORIGIN_Y;
  - cell_index = 0, select_index = 0;
  - moved = 0, select_strobe = 0;
  - all btn_q = 1, so a button held through reset release does not fire.
- Reset mid-move cancels the move. The first action after release needs a fresh rising edge.

## Test plan
- Reset then idle: posx=73, posy=47, cell_index=0, no strobes. Hold btn_right through reset release -> no move until it is released and pressed again.
- Default params, press right x3 (WRAP=1): posx 283, 493, 73. cell_index 1, 2, 0. moved pulses 3 times, each 1 cycle wide.
- WRAP=0 at col=0, press left: col stays 0, moved=0. Then press down x3: posy 205, 363, 363; moved pulses 2 times.
- Same cycle right+left rise: no x change. Same cycle right+down from (0,0): cell_index=4, posx=283, posy=205, single moved pulse.
- At cell 4, select and right rise in the same cycle: select_index=4, select_strobe 1 cycle, cell_index=5. Holding select for 10 cycles gives one strobe.
- At cell 8, home+down+right rise together: col=row=0, posx=73, posy=47, moved=1. Assert rst_n low asynchronously mid-cycle: outputs reset immediately.
